// File: rtl/axi_read_arbiter.sv
// 2:1 AXI3 read-channel arbiter: dcache (requester 0) and icache (requester 1)
// share one external AR/R port, one burst at a time, round-robin on contention.
module axi_read_arbiter #(
    parameter int AR_W       = 45,
    parameter int R_W        = 39,
    parameter int FIRST_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        s_arvalid,
    output logic [1:0]        s_arready,
    input  logic [2*AR_W-1:0] s_ar,
    output logic [1:0]        s_rvalid,
    input  logic [1:0]        s_rready,
    output logic [2*R_W-1:0]  s_r,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [AR_W-1:0]   m_ar,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [R_W-1:0]    m_r
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic FIRST = 1'(FIRST_PRIO);

    state_t state, state_d;
    logic   grant, grant_d;
    logic   last, last_d;
    logic [AR_W-1:0] ar_req [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= ~FIRST;
        end else begin
            state <= state_d;
            grant <= grant_d;
            last  <= last_d;
        end
    end

    always_comb begin
        state_d   = state;
        grant_d   = grant;
        last_d    = last;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state)
            IDLE: begin
                // Contention goes to whoever was not served last; a lone requester always wins.
                if (|s_arvalid) begin
                    grant_d = (s_arvalid == 2'b11) ? ~last : s_arvalid[1];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = DATA;
                    last_d  = grant;
                end
            end
            DATA: begin
                m_rready = s_rready[grant];
                if (m_rvalid && s_rready[grant] && m_r[0])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-requester slicing and routing, all steered by the registered grant.
    for (genvar g = 0; g < 2; g++) begin : g_req
        assign ar_req[g]    = s_ar[g*AR_W +: AR_W];
        assign s_arready[g] = (state == ADDR) && (grant == 1'(g)) && m_arready;
        assign s_rvalid[g]  = (state == DATA) && (grant == 1'(g)) && m_rvalid;
    end

    assign m_ar = ar_req[grant];
    assign s_r  = {m_r, m_r};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: requester/slave models driven per
// cycle, checked against an ownership-level model of the sharing rules.
module tb_axi_read_arbiter;
    localparam int AR_W = 45;
    localparam int R_W  = 39;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [2*AR_W-1:0] s_ar;
    logic [2*R_W-1:0]  s_r;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AR_W-1:0]   m_ar;
    logic [R_W-1:0]    m_r;

    always #5 clk = ~clk;

    axi_read_arbiter #(.AR_W(AR_W), .R_W(R_W), .FIRST_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r(m_r)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [3:0] len; logic [3:0] id; } req_t;
    typedef struct { logic [31:0] data; logic last; logic [3:0] id; } beat_t;

    req_t  req_q [2][$];
    beat_t exp_q [2][$];
    int    grant_log [$];
    bit    [1:0] pres;
    bit    [1:0] allow;
    bit    rnd_allow;
    int    ar_pct, rv_pct, rr_pct, ar_hold;
    int    rbeats [2];
    int    arv_cyc;

    // ownership model: who holds the port, and whether its address is still pending
    int owner;
    bit ar_pend;
    int last_srv;

    // external slave model
    bit          sb, rv;
    logic [31:0] sa;
    logic [3:0]  sid;
    int          sl, sbeat;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h1FC0_0000) ? 32'hDEAD_BEEF : (a * 32'h9E37_79B1) + 32'h1;
    endfunction

    function automatic logic [AR_W-1:0] pack_ar(input req_t r);
        return {r.id, r.addr, r.len, 3'b010, 2'b01};
    endfunction

    task automatic reset_models();
        for (int i = 0; i < 2; i++) begin
            req_q[i].delete();
            exp_q[i].delete();
            rbeats[i] = 0;
        end
        grant_log.delete();
        pres = '0; allow = '1; rnd_allow = 1'b0;
        owner = -1; ar_pend = 1'b0; last_srv = 1;
        sb = 1'b0; rv = 1'b0; sbeat = 0; sl = 0; sa = '0; sid = '0;
        ar_hold = 0; arv_cyc = 0;
        s_arvalid = '0; s_rready = '0; s_ar = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_r = '0;
    endtask

    task automatic push_req(input int who, input logic [31:0] addr, input logic [3:0] len);
        req_t r;
        r.addr = addr; r.len = len; r.id = 4'($urandom);
        req_q[who].push_back(r);
    endtask

    task automatic cycle();
        logic [1:0] e_sar, e_srv;
        logic       e_mav, e_mrr;
        req_t       r;
        beat_t      e, b;
        @(negedge clk);
        if (rnd_allow) allow = 2'($urandom);
        for (int i = 0; i < 2; i++) begin
            if (!pres[i] && allow[i] && req_q[i].size() > 0) pres[i] = 1'b1;
            s_ar[i*AR_W +: AR_W] = pres[i] ? pack_ar(req_q[i][0]) : AR_W'({$urandom, $urandom});
            s_rready[i] = ($urandom_range(0, 99) < rr_pct);
        end
        s_arvalid = pres;
        if (sb) m_arready = 1'b0;
        else if (ar_hold > 0 && m_arvalid) begin m_arready = 1'b0; ar_hold--; end
        else m_arready = ($urandom_range(0, 99) < ar_pct);
        if (!sb) rv = 1'b0;
        else if (!rv) rv = ($urandom_range(0, 99) < rv_pct);
        m_rvalid = rv;
        m_r = {sid, memf(sa + 32'(4 * sbeat)), 2'b00, (sbeat == sl)};
        #1;
        e_sar = '0; e_srv = '0; e_mrr = 1'b0;
        e_mav = (owner >= 0) && ar_pend;
        if (owner >= 0 && ar_pend) e_sar[owner] = m_arready;
        if (owner >= 0 && !ar_pend) begin
            e_srv[owner] = m_rvalid;
            e_mrr = s_rready[owner];
        end
        chk("ctl", {m_arvalid, m_rready, s_arready, s_rvalid}, {e_mav, e_mrr, e_sar, e_srv});
        if (m_arvalid) arv_cyc++;
        if (e_mav && req_q[owner].size() > 0) chk("m_ar", m_ar, pack_ar(req_q[owner][0]));
        if (|s_rvalid) begin
            chk("s_r_hi", s_r[2*R_W-1:R_W], m_r);
            chk("s_r_lo", s_r[R_W-1:0], m_r);
        end
        for (int i = 0; i < 2; i++) begin
            if (s_arvalid[i] && s_arready[i]) begin
                r = req_q[i].pop_front();
                pres[i] = 1'b0;
                grant_log.push_back(i);
                for (int k = 0; k <= int'(r.len); k++) begin
                    b.data = memf(r.addr + 32'(4 * k)); b.last = (k == int'(r.len)); b.id = r.id;
                    exp_q[i].push_back(b);
                end
            end
            if (s_rvalid[i] && s_rready[i]) begin
                rbeats[i]++;
                if (exp_q[i].size() == 0) chk($sformatf("r%0d_unexpected_beat", i), 0, 1);
                else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("r%0d_beat", i), {s_r[R_W-1 -: 4], s_r[34:3], s_r[0]},
                        {e.id, e.data, e.last});
                end
            end
        end
        // ownership model update
        if (owner < 0) begin
            if (|s_arvalid) begin
                owner = (s_arvalid == 2'b11) ? 1 - last_srv : (s_arvalid[1] ? 1 : 0);
                ar_pend = 1'b1;
            end
        end else if (ar_pend) begin
            if (m_arready) begin ar_pend = 1'b0; last_srv = owner; end
        end else if (m_rvalid && s_rready[owner] && m_r[0]) owner = -1;
        // slave update
        if (m_arvalid && m_arready) begin
            sb = 1'b1; sid = m_ar[44:41]; sa = m_ar[40:9]; sl = int'(m_ar[8:5]); sbeat = 0;
        end else if (m_rvalid && m_rready) begin
            rv = 1'b0;
            if (sbeat == sl) sb = 1'b0; else sbeat++;
        end
    endtask

    task automatic run(input string tag, input int max_cyc);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            cycle();
            n++;
            done = (req_q[0].size() == 0) && (req_q[1].size() == 0) && (exp_q[0].size() == 0) &&
                   (exp_q[1].size() == 0) && (owner < 0) && !sb;
        end
        chk({tag, "_drain"}, done, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        reset_models();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        reset_models();
        ar_pct = 100; rv_pct = 100; rr_pct = 100;
        repeat (2) @(negedge clk);
        #1 chk("reset_out", {m_arvalid, m_rready, s_arready, s_rvalid}, 6'd0);
        rst = 1'b0;

        // single dcache beat from the boot vector
        push_req(0, 32'h1FC0_0000, 4'd0);
        run("t1", 50);
        chk("t1_grant", grant_log[0], 0);
        chk("t1_beats", rbeats[0], 1);

        // simultaneous pairs from reset: dcache, icache, dcache, icache
        pulse_reset();
        ar_pct = 100; rv_pct = 100; rr_pct = 100;
        for (int k = 0; k < 2; k++) begin
            push_req(0, 32'h100 + 32'(64 * k), 4'd1);
            push_req(1, 32'h800 + 32'(64 * k), 4'd1);
        end
        run("t2", 200);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) chk($sformatf("t2_grant%0d", k), grant_log[k], k % 2);
        chk("t2_ngrant", grant_log.size(), 4);

        // icache 8-beat burst with R gaps and stalls
        rv_pct = 40; rr_pct = 50; rbeats[0] = 0; rbeats[1] = 0;
        push_req(1, 32'h4000, 4'd7);
        run("t3", 400);
        chk("t3_beats_i", rbeats[1], 8);
        chk("t3_beats_d", rbeats[0], 0);

        // AR stalled 5 cycles
        rv_pct = 100; rr_pct = 100; ar_hold = 5; arv_cyc = 0;
        push_req(0, 32'h2000, 4'd1);
        run("t4", 100);
        chk("t4_arvalid_cycles", arv_cyc, 6);

        // async reset at beat 3 of 8
        push_req(0, 32'h3000, 4'd7);
        rbeats[0] = 0;
        for (int n = 0; n < 100 && rbeats[0] < 3; n++) cycle();
        chk("t5_reached_beat3", rbeats[0], 3);
        #1 rst = 1'b1;
        #1 chk("t5_async_rst", {m_arvalid, m_rready, s_arready, s_rvalid}, 6'd0);
        @(negedge clk);
        reset_models();
        @(negedge clk);
        rst = 1'b0;
        ar_pct = 100; rv_pct = 100; rr_pct = 100;
        push_req(0, 32'h5000, 4'd2);
        push_req(1, 32'h6000, 4'd2);
        run("t5", 100);
        if (grant_log.size() == 2) begin
            chk("t5_grant0", grant_log[0], 0);
            chk("t5_grant1", grant_log[1], 1);
        end else chk("t5_ngrant", grant_log.size(), 2);

        // random two-requester traffic
        pulse_reset();
        rnd_allow = 1'b1;
        ar_pct = 60; rv_pct = 60; rr_pct = 60;
        for (int k = 0; k < 60; k++)
            push_req(int'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 7)));
        run("t6", 20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
